// File: rtl/write_fifo_ctrl.sv
// write_fifo_ctrl: write-side pointer/flag controller of a dual-clock FIFO (optional sticky overflow via WRITE_FIFO_OVERFLOW_EN)
module write_fifo_ctrl #(
    parameter int fifo_addr_size  = 5,
    parameter int almost_full_gap = 3
) (
    input  logic                      clk_w,
    input  logic                      rst_w,
    input  logic                      w_en,
    input  logic [fifo_addr_size:0]   raddr_gray,
    output logic [fifo_addr_size-1:0] w_addr,
    output logic                      mem_we,
    output logic [fifo_addr_size:0]   waddr_gray,
    output logic                      full,
    output logic                      almost_full,
    output logic                      overflow
);
    localparam int AW = fifo_addr_size + 1;
    localparam logic [AW-1:0] DEPTH_V = AW'(2 ** fifo_addr_size);
    localparam logic [AW-1:0] GAP_V   = AW'(almost_full_gap);

    logic [AW-1:0] w_ptr, w_ptr_next, rsync1, rsync2, r_ptr_sync, used, free;
    logic          w_acc;

    // mem_we is held low during reset so no write lands while the pointers are being cleared
    assign w_acc      = w_en & ~full & ~rst_w;
    assign mem_we     = w_acc;
    assign w_addr     = w_ptr[fifo_addr_size-1:0];
    assign w_ptr_next = w_ptr + AW'(w_acc);
    assign used       = w_ptr_next - r_ptr_sync;
    assign free       = DEPTH_V - used;

    // Gray-to-binary of the synchronised read pointer
    always_comb begin
        r_ptr_sync = '0;
        for (int i = 0; i < AW; i++) r_ptr_sync[i] = ^(rsync2 >> i);
    end

    // pointer, Gray publish, read-pointer synchroniser and flags
    always_ff @(posedge clk_w) begin
        if (rst_w) begin
            w_ptr       <= '0;
            waddr_gray  <= '0;
            rsync1      <= '0;
            rsync2      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            w_ptr       <= w_ptr_next;
            waddr_gray  <= w_ptr_next ^ (w_ptr_next >> 1);
            rsync1      <= raddr_gray;
            rsync2      <= rsync1;
            full        <= used == DEPTH_V;
            almost_full <= free < GAP_V;
        end
    end

`ifdef WRITE_FIFO_OVERFLOW_EN
    // sticky record of any write attempted while full
    always_ff @(posedge clk_w) begin
        if (rst_w) overflow <= 1'b0;
        else overflow <= overflow | (w_en & full);
    end
`else
    assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_write_fifo_ctrl.sv
// tb_write_fifo_ctrl: scoreboard bench for write_fifo_ctrl with directed vectors
module tb_write_fifo_ctrl;
    logic       clk_w = 1'b0;
    logic       rst_w = 1'b1;
    logic       w_en = 1'b1;
    logic [5:0] raddr_gray = '0;
    logic [4:0] w_addr;
    logic       mem_we;
    logic [5:0] waddr_gray;
    logic       full, almost_full, overflow;

`ifdef WRITE_FIFO_OVERFLOW_EN
    localparam logic OV1 = 1'b1;
`else
    localparam logic OV1 = 1'b0;
`endif
    localparam logic [5:0] M_WA = 6'd1, M_WG = 6'd2, M_FU = 6'd4, M_AF = 6'd8, M_OV = 6'd16, M_WE = 6'd32, ALL = 6'd63;

    typedef struct {
        string      name;
        logic [5:0] m;
        logic [4:0] wa;
        logic [5:0] wg;
        logic       fu, af, ov, we;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    write_fifo_ctrl dut (
        .clk_w(clk_w), .rst_w(rst_w), .w_en(w_en), .raddr_gray(raddr_gray),
        .w_addr(w_addr), .mem_we(mem_we), .waddr_gray(waddr_gray),
        .full(full), .almost_full(almost_full), .overflow(overflow)
    );

    always #5 clk_w = ~clk_w;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // monitor: pops every pending expectation and compares against the outputs
    always @(negedge clk_w) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.m[0]) chk({e.name, ".w_addr"}, int'(w_addr), int'(e.wa));
            if (e.m[1]) chk({e.name, ".waddr_gray"}, int'(waddr_gray), int'(e.wg));
            if (e.m[2]) chk({e.name, ".full"}, int'(full), int'(e.fu));
            if (e.m[3]) chk({e.name, ".almost_full"}, int'(almost_full), int'(e.af));
            if (e.m[4]) chk({e.name, ".overflow"}, int'(overflow), int'(e.ov));
            if (e.m[5]) chk({e.name, ".mem_we"}, int'(mem_we), int'(e.we));
        end
    end

    task automatic push(input string nm, input logic [5:0] m, input logic [4:0] wa, input logic [5:0] wg,
                        input logic fu, input logic af, input logic ov, input logic we);
        exp_t e;
        e.name = nm; e.m = m; e.wa = wa; e.wg = wg; e.fu = fu; e.af = af; e.ov = ov; e.we = we;
        sb.push_back(e);
    endtask

    // inputs change just after the falling edge; returns just after the next rising edge
    task automatic cyc(input logic r, input logic we, input logic [5:0] rg);
        @(negedge clk_w);
        #1;
        rst_w = r; w_en = we; raddr_gray = rg;
        @(posedge clk_w);
        #1;
    endtask

    function automatic logic [5:0] gray(input int b);
        logic [5:0] v;
        v = 6'(b);
        return v ^ (v >> 1);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc(1, 1, 0);
        push("reset1", ALL, 5'd0, 6'd0, 0, 0, 0, 0);
        cyc(1, 1, 0);
        push("reset2", ALL, 5'd0, 6'd0, 0, 0, 0, 0);
        for (int i = 1; i <= 28; i++) cyc(0, 1, 0);
        cyc(0, 1, 0);
        push("w29", ALL, 5'd29, 6'b010011, 0, 0, 0, 1);
        cyc(0, 1, 0);
        push("w30", M_WA | M_FU | M_AF, 5'd30, 6'd0, 0, 1, 0, 0);
        cyc(0, 1, 0);
        push("w31", M_WA | M_FU | M_AF, 5'd31, 6'd0, 0, 1, 0, 0);
        cyc(0, 1, 0);
        push("w32", ALL, 5'd0, 6'b110000, 1, 1, 0, 0);
        cyc(0, 1, 0);
        push("w33", ALL, 5'd0, 6'b110000, 1, 1, OV1, 0);
        cyc(0, 0, 6'b000001);
        push("rel1_e1", M_FU | M_AF | M_OV, 5'd0, 6'd0, 1, 1, OV1, 0);
        cyc(0, 0, 6'b000001);
        push("rel1_e2", M_FU | M_AF, 5'd0, 6'd0, 1, 1, 0, 0);
        cyc(0, 0, 6'b000001);
        push("rel1_e3", ALL, 5'd0, 6'b110000, 0, 1, OV1, 0);
        cyc(0, 0, 6'b000110);
        push("rel4_e1", M_AF, 5'd0, 6'd0, 0, 1, 0, 0);
        cyc(0, 0, 6'b000110);
        push("rel4_e2", M_AF, 5'd0, 6'd0, 0, 1, 0, 0);
        cyc(0, 0, 6'b000110);
        push("rel4_e3", M_FU | M_AF | M_OV, 5'd0, 6'd0, 0, 0, OV1, 0);
        cyc(1, 0, 0);
        push("reset3", ALL, 5'd0, 6'd0, 0, 0, 0, 0);
        for (int i = 1; i <= 40; i++) begin
            cyc(0, 1, (i >= 3) ? gray(i - 3) : 6'd0);
            push($sformatf("wrap%0d", i), ALL, 5'(i % 32), gray(i), 0, 0, 0, 1);
        end
        push("wrap_end", M_WA | M_WG, 5'd8, 6'b111100, 0, 0, 0, 0);
        cyc(1, 0, 0);
        push("reset4", ALL, 5'd0, 6'd0, 0, 0, 0, 0);
        for (int i = 1; i <= 17; i++) cyc(0, 1, 0);
        push("w17", M_WA | M_WG, 5'd17, 6'b011001, 0, 0, 0, 0);
        cyc(1, 1, 0);
        push("reset_mid", ALL, 5'd0, 6'd0, 0, 0, 0, 0);
        cyc(0, 1, 0);
        push("resume", ALL, 5'd1, 6'b000001, 0, 0, 0, 1);
        @(negedge clk_w);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
